mem_responder: RTL and testbench

//  Responder end of the memory-stage data interface: accepts a group of up to two lane requests
//  (load/store) and services them in lane order against an internal word array with WAIT_CYCLES

---
 rtl/mem_responder_pkg.sv | 31 +++
 rtl/mem_responder_if.sv | 23 ++
 rtl/mem_responder_sram_word_array.sv | 28 ++
 rtl/mem_responder.sv | 127 ++++++++++++
 tb/tb_mem_responder.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory-stage responder.
package mem_responder_pkg;

  localparam int NUM_LANES = 2;

  // FSM encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_req_lane_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mem_resp_lane_t;

  // A lane errors when the byte address is not word aligned or its word index
  // falls outside the array.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Two-lane request/response bundle between the memory stage and the responder.
interface mem_responder_if;
  logic [1:0]       req_valid;
  logic [1:0]       req_we;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0][3:0]  req_be;
  logic             req_ready;
  logic             resp_valid;
  logic [1:0][31:0] resp_rdata;
  logic [1:0]       resp_err;
  logic             busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/mem_responder_sram_word_array.sv
// Single-port word array: combinational read, byte-enabled synchronous write.
// Contents are deliberately not reset.
module sram_word_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Write only the enabled byte lanes of the addressed word.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Responder end of the memory-stage data interface. Services up to two lane
// requests in lane order with WAIT_CYCLES wait states before each access.
//
//   state  | meaning
//   IDLE   | ready for a new group; latches it on any valid lane
//   WAIT   | wait states before the current lane's access
//   ACCESS | one-cycle read or write for the lane selected by ptr
//   DONE   | resp_valid pulse for the whole group
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic             clk,
  input logic             rst_n,
  mem_responder_if.slave  bus
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  // With no wait states a lane goes straight to its access cycle.
  localparam logic [1:0] LANE_ST   = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;

  logic [1:0]                     state_q, state_d;
  logic [3:0]                     cnt_q, cnt_d;
  logic                           ptr_q, ptr_d;
  mem_req_lane_t  [NUM_LANES-1:0] req_q, req_d;
  mem_resp_lane_t [NUM_LANES-1:0] resp_q, resp_d;

  mem_req_lane_t cur;
  logic          cur_err;
  logic          mem_we;
  logic [31:0]   mem_rdata;

  assign cur     = req_q[ptr_q];
  assign cur_err = addr_err(cur.addr, DEPTH_WORDS);
  assign mem_we  = (state_q == ST_ACCESS) && cur.valid && cur.we && !cur_err;

  sram_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (cur.addr[AW+1:2]),
    .be_i    (cur.be),
    .wdata_i (cur.wdata),
    .rdata_o (mem_rdata)
  );

  // Next-state logic for the FSM, wait counter, lane pointer and responses.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    req_d   = req_q;
    resp_d  = resp_q;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          for (int l = 0; l < NUM_LANES; l++) begin
            req_d[l].valid = bus.req_valid[l];
            req_d[l].we    = bus.req_we[l];
            req_d[l].addr  = bus.req_addr[l];
            req_d[l].wdata = bus.req_wdata[l];
            req_d[l].be    = bus.req_be[l];
          end
          resp_d  = '0;
          ptr_d   = ~bus.req_valid[0];
          cnt_d   = WAIT_INIT;
          state_d = LANE_ST;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cur.valid) begin
          if (cur_err) begin
            resp_d[ptr_q].rdata = '0;
            resp_d[ptr_q].err   = 1'b1;
          end else if (!cur.we) begin
            resp_d[ptr_q].rdata = mem_rdata;
          end
        end
        if (!ptr_q && req_q[1].valid) begin
          ptr_d   = 1'b1;
          cnt_d   = WAIT_INIT;
          state_d = LANE_ST;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register update; reset aborts any group in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      req_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      req_q   <= req_d;
      resp_q  <= resp_d;
    end
  end

  // Outputs decoded from state and the response registers.
  always_comb begin
    bus.req_ready  = (state_q == ST_IDLE);
    bus.busy       = (state_q != ST_IDLE);
    bus.resp_valid = (state_q == ST_DONE);
    for (int l = 0; l < NUM_LANES; l++) begin
      bus.resp_rdata[l] = resp_q[l].rdata;
      bus.resp_err[l]   = resp_q[l].err;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states and one
// with none, sharing clock and reset.
module tb_mem_responder;
  import mem_responder_pkg::*;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  mem_responder_if bus2 ();
  mem_responder_if bus0 ();

  mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_w2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_w0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit w0, input logic [1:0] v, input logic [1:0] we,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [3:0] b0, input logic [3:0] b1);
    if (w0) begin
      bus0.req_valid = v;  bus0.req_we = we;
      bus0.req_addr[0] = a0;  bus0.req_addr[1] = a1;
      bus0.req_wdata[0] = d0; bus0.req_wdata[1] = d1;
      bus0.req_be[0] = b0;    bus0.req_be[1] = b1;
    end else begin
      bus2.req_valid = v;  bus2.req_we = we;
      bus2.req_addr[0] = a0;  bus2.req_addr[1] = a1;
      bus2.req_wdata[0] = d0; bus2.req_wdata[1] = d1;
      bus2.req_be[0] = b0;    bus2.req_be[1] = b1;
    end
  endtask

  // Presents a group for one cycle (cycle T) and reports the cycle offset of
  // resp_valid plus how many cycles busy was high / req_ready was low. With
  // toggle set, junk stores are waved at the bus while the DUT is busy.
  task automatic run_group(input bit w0, input logic [1:0] v, input logic [1:0] we,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [3:0] b0, input logic [3:0] b1, input bit toggle,
                           output int lat, output int nbusy, output int nnr);
    logic rv, bz, rd;
    @(negedge clk);
    drive(w0, v, we, a0, a1, d0, d1, b0, b1);
    lat = -1; nbusy = 0; nnr = 0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      rv = w0 ? bus0.resp_valid : bus2.resp_valid;
      bz = w0 ? bus0.busy       : bus2.busy;
      rd = w0 ? bus0.req_ready  : bus2.req_ready;
      if (bz) nbusy++;
      if (!rd) nnr++;
      if (rv) lat = k;
      if (toggle && !rv && k[0])
        drive(w0, 2'b11, 2'b11, a0, a0, 32'h0, 32'h0, 4'hF, 4'hF);
      else
        drive(w0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    end
  endtask

  int lat, nb, nr;

  initial begin
    drive(1'b0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    drive(1'b1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst ready",  bus2.req_ready, 1);
    chk("rst rvalid", bus2.resp_valid, 0);
    chk("rst rdata",  bus2.resp_rdata, 0);
    chk("rst err",    bus2.resp_err, 0);
    chk("rst busy",   bus2.busy, 0);
    chk("rst ready0", bus0.req_ready, 1);
    rst_n = 1'b1;

    // 1: full-word store then load back
    run_group(0, 2'b01, 2'b01, 32'h100, 0, 32'hDEADBEEF, 0, 4'hF, 0, 0, lat, nb, nr);
    chk("t1 st lat", lat, 4);
    chk("t1 st busy", nb, 4);
    chk("t1 st err", bus2.resp_err, 0);
    run_group(0, 2'b01, 2'b00, 32'h100, 0, 0, 0, 0, 0, 0, lat, nb, nr);
    chk("t1 ld lat", lat, 4);
    chk("t1 ld rd0", bus2.resp_rdata[0], 32'hDEADBEEF);
    chk("t1 ld rd1", bus2.resp_rdata[1], 0);
    chk("t1 ld err", bus2.resp_err, 0);
    @(negedge clk);
    chk("t1 pulse", bus2.resp_valid, 0);
    chk("t1 hold", bus2.resp_rdata[0], 32'hDEADBEEF);
    chk("t1 ready", bus2.req_ready, 1);

    // 2: partial store then same-word load in lane 1
    run_group(0, 2'b01, 2'b01, 32'h40, 0, 32'hAABBCCDD, 0, 4'hF, 0, 0, lat, nb, nr);
    chk("t2 pre lat", lat, 4);
    run_group(0, 2'b11, 2'b01, 32'h40, 32'h40, 32'h11223344, 0, 4'b0101, 0, 0, lat, nb, nr);
    chk("t2 lat", lat, 7);
    chk("t2 rd1", bus2.resp_rdata[1], 32'hAA22CC44);
    chk("t2 rd0", bus2.resp_rdata[0], 0);
    chk("t2 err", bus2.resp_err, 0);

    // 3: no wait states, two stores then two loads
    run_group(1, 2'b11, 2'b11, 32'h0, 32'h4, 32'h12345678, 32'h9ABCDEF0, 4'hF, 4'hF, 0, lat, nb, nr);
    chk("t3 st lat", lat, 3);
    run_group(1, 2'b11, 2'b00, 32'h4, 32'h0, 0, 0, 0, 0, 0, lat, nb, nr);
    chk("t3 lat", lat, 3);
    chk("t3 busy", nb, 3);
    chk("t3 notrdy", nr, 3);
    chk("t3 rd0", bus0.resp_rdata[0], 32'h9ABCDEF0);
    chk("t3 rd1", bus0.resp_rdata[1], 32'h12345678);
    @(negedge clk);
    chk("t3 idle", bus0.busy, 0);

    // 4: misaligned and out-of-range lanes
    run_group(0, 2'b11, 2'b00, 32'h102, 32'h4000_0000, 0, 0, 0, 0, 0, lat, nb, nr);
    chk("t4 lat", lat, 7);
    chk("t4 err", bus2.resp_err, 2'b11);
    chk("t4 rdata", bus2.resp_rdata, 0);
    run_group(0, 2'b11, 2'b11, 32'h42, 32'h1000, 32'h0, 32'h0, 4'hF, 4'hF, 0, lat, nb, nr);
    chk("t4 st err", bus2.resp_err, 2'b11);
    run_group(0, 2'b11, 2'b11, 32'hFFC, 32'h1004, 32'hCAFEF00D, 32'h0, 4'hF, 4'hF, 0, lat, nb, nr);
    chk("t4 edge err", bus2.resp_err, 2'b10);
    run_group(0, 2'b11, 2'b00, 32'h40, 32'hFFC, 0, 0, 0, 0, 0, lat, nb, nr);
    chk("t4 keep 40", bus2.resp_rdata[0], 32'hAA22CC44);
    chk("t4 last wd", bus2.resp_rdata[1], 32'hCAFEF00D);
    chk("t4 ok err", bus2.resp_err, 0);

    // 5: lane 1 only, with request noise while busy
    run_group(0, 2'b10, 2'b00, 0, 32'h100, 0, 0, 0, 0, 1, lat, nb, nr);
    chk("t5 lat", lat, 4);
    chk("t5 busy", nb, 4);
    chk("t5 rd0", bus2.resp_rdata[0], 0);
    chk("t5 rd1", bus2.resp_rdata[1], 32'hDEADBEEF);
    chk("t5 err", bus2.resp_err, 0);
    run_group(0, 2'b01, 2'b00, 32'h100, 0, 0, 0, 0, 0, 0, lat, nb, nr);
    chk("t5 noise", bus2.resp_rdata[0], 32'hDEADBEEF);

    // 6: reset during the wait before a store
    run_group(0, 2'b01, 2'b01, 32'h80, 0, 32'h01010101, 0, 4'hF, 0, 0, lat, nb, nr);
    chk("t6 pre lat", lat, 4);
    @(negedge clk);
    drive(0, 2'b01, 2'b01, 32'h80, 0, 32'h0BADF00D, 0, 4'hF, 0);
    @(negedge clk);
    drive(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    chk("t6 in wait", bus2.busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6 busy", bus2.busy, 0);
    chk("t6 ready", bus2.req_ready, 1);
    chk("t6 rvalid", bus2.resp_valid, 0);
    nb = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus2.resp_valid) nb++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus2.resp_valid) nb++;
    end
    chk("t6 no resp", nb, 0);
    run_group(0, 2'b01, 2'b00, 32'h80, 0, 0, 0, 0, 0, 0, lat, nb, nr);
    chk("t6 word", bus2.resp_rdata[0], 32'h01010101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
